meta_state_ctrl: RTL and testbench

- Controller that sits directly upstream of the 4-way, 512-set, 2-bit-per-way two-port metadata SRAM array.
- Clears every set after reset or on a flush command.
- Arbitrates cache-pipeline read and write requests onto the array's single read port and single write port.
- Returns read data with fixed 1-cycle latency, forwarding same-cycle writes so a response never shows stale state.

---
 rtl/meta_state_ctrl_pkg.sv | 27 ++
 rtl/meta_state_ctrl_if.sv | 30 +++
 rtl/meta_fwd_merge.sv | 20 ++
 rtl/meta_state_ctrl.sv | 100 ++++++++++
 tb/tb_meta_state_ctrl.sv | 192 +++++++++++++++++++
 5 files changed

// File: rtl/meta_state_ctrl_pkg.sv
// rtl/meta_state_ctrl_pkg.sv - shared geometry, state enums and helpers for the metadata controller
package meta_state_ctrl_pkg;

    localparam int SETS    = 512;
    localparam int SET_W   = 9;
    localparam int WAYS    = 4;
    localparam int STATE_W = 2;
    localparam int LINE_W  = WAYS * STATE_W;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } ctrl_state_e;

    // Only META_INVALID is interpreted here; it is what the clear sweep writes.
    typedef enum logic [STATE_W-1:0] {
        META_INVALID   = 2'd0,
        META_SHARED    = 2'd1,
        META_EXCLUSIVE = 2'd2,
        META_DIRTY     = 2'd3
    } meta_e;

    function automatic logic [LINE_W-1:0] replicate_state(input logic [STATE_W-1:0] s);
        return {WAYS{s}};
    endfunction

endpackage

// File: rtl/meta_state_ctrl_if.sv
// rtl/meta_state_ctrl_if.sv - cache-pipeline request/response bundle for the metadata controller
interface meta_state_ctrl_if;
    import meta_state_ctrl_pkg::*;

    logic                 io_init_done;
    logic                 io_flush;
    logic                 io_rd_valid;
    logic                 io_rd_ready;
    logic [SET_W-1:0]     io_rd_set;
    logic                 io_resp_valid;
    logic [LINE_W-1:0]    io_resp_state;
    logic                 io_wr_valid;
    logic                 io_wr_ready;
    logic [SET_W-1:0]     io_wr_set;
    logic [WAYS-1:0]      io_wr_wayOH;
    logic [STATE_W-1:0]   io_wr_state;

    modport slave (
        input  io_flush, io_rd_valid, io_rd_set,
               io_wr_valid, io_wr_set, io_wr_wayOH, io_wr_state,
        output io_init_done, io_rd_ready, io_resp_valid, io_resp_state, io_wr_ready
    );

    modport master (
        output io_flush, io_rd_valid, io_rd_set,
               io_wr_valid, io_wr_set, io_wr_wayOH, io_wr_state,
        input  io_init_done, io_rd_ready, io_resp_valid, io_resp_state, io_wr_ready
    );

endinterface

// File: rtl/meta_fwd_merge.sv
// rtl/meta_fwd_merge.sv - per-way select between a forwarded same-cycle write and array read data
module meta_fwd_merge
    import meta_state_ctrl_pkg::*;
(
    input  logic [WAYS-1:0]    fwd_mask,
    input  logic [STATE_W-1:0] fwd_state,
    input  logic [LINE_W-1:0]  arr_data,
    output logic [LINE_W-1:0]  merged
);

    always_comb begin
        merged = arr_data;
        for (int i = 0; i < WAYS; i++) begin
            if (fwd_mask[i]) begin
                merged[i*STATE_W +: STATE_W] = fwd_state;
            end
        end
    end

endmodule

// File: rtl/meta_state_ctrl.sv
// rtl/meta_state_ctrl.sv - clears the metadata array, then arbitrates pipeline reads/writes onto it
module meta_state_ctrl
    import meta_state_ctrl_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    meta_state_ctrl_if.slave    io,
    output logic [SET_W-1:0]    arr_r_addr,
    input  logic [LINE_W-1:0]   arr_r_data,
    output logic                arr_w_en,
    output logic [SET_W-1:0]    arr_w_addr,
    output logic [LINE_W-1:0]   arr_w_data,
    output logic [WAYS-1:0]     arr_w_maskOH
);

    ctrl_state_e          state;
    logic [SET_W-1:0]     sweep_cnt;
    logic [SET_W-1:0]     r_addr_q;
    logic                 resp_valid_q;
    logic [WAYS-1:0]      fwd_mask_q;
    logic [STATE_W-1:0]   fwd_state_q;

    logic run;
    logic rd_acc;
    logic wr_acc;
    logic wr_hit;

    assign run    = (state == RUN);
    assign rd_acc = run & io.io_rd_valid;
    assign wr_acc = run & io.io_wr_valid & (|io.io_wr_wayOH);
    // The array returns old data on read-during-write, so a same-set write must be forwarded.
    assign wr_hit = rd_acc & wr_acc & (io.io_wr_set == io.io_rd_set);

    always_comb begin
        if (run) begin
            arr_w_en     = wr_acc;
            arr_w_addr   = io.io_wr_set;
            arr_w_data   = replicate_state(io.io_wr_state);
            arr_w_maskOH = io.io_wr_wayOH;
        end else begin
            arr_w_en     = 1'b1;
            arr_w_addr   = sweep_cnt;
            arr_w_data   = replicate_state(META_INVALID);
            arr_w_maskOH = '1;
        end
    end

    assign arr_r_addr = rd_acc ? io.io_rd_set : r_addr_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= INIT;
            sweep_cnt    <= '0;
            r_addr_q     <= '0;
            resp_valid_q <= 1'b0;
            fwd_mask_q   <= '0;
            fwd_state_q  <= '0;
        end else begin
            resp_valid_q <= rd_acc;
            if (rd_acc) begin
                r_addr_q    <= io.io_rd_set;
                fwd_mask_q  <= wr_hit ? io.io_wr_wayOH : '0;
                fwd_state_q <= io.io_wr_state;
            end
            case (state)
                INIT: begin
                    if (sweep_cnt == SET_W'(SETS - 1)) begin
                        state     <= RUN;
                        sweep_cnt <= '0;
                    end else begin
                        sweep_cnt <= sweep_cnt + SET_W'(1);
                    end
                end
                RUN: begin
                    if (io.io_flush) begin
                        state     <= INIT;
                        sweep_cnt <= '0;
                    end
                end
                default: begin
                    state     <= INIT;
                    sweep_cnt <= '0;
                end
            endcase
        end
    end

    meta_fwd_merge u_merge (
        .fwd_mask  (fwd_mask_q),
        .fwd_state (fwd_state_q),
        .arr_data  (arr_r_data),
        .merged    (io.io_resp_state)
    );

    assign io.io_resp_valid = resp_valid_q;
    assign io.io_init_done  = run;
    assign io.io_rd_ready   = run;
    assign io.io_wr_ready   = run;

endmodule

// File: tb/tb_meta_state_ctrl.sv
// tb/tb_meta_state_ctrl.sv - directed and random checks of meta_state_ctrl against a set-level model
module tb_meta_state_ctrl;
    import meta_state_ctrl_pkg::*;

    logic                clock = 1'b0;
    logic                reset;
    logic [SET_W-1:0]    arr_r_addr;
    logic [LINE_W-1:0]   arr_r_data;
    logic                arr_w_en;
    logic [SET_W-1:0]    arr_w_addr;
    logic [LINE_W-1:0]   arr_w_data;
    logic [WAYS-1:0]     arr_w_maskOH;

    meta_state_ctrl_if bus ();

    meta_state_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .io           (bus),
        .arr_r_addr   (arr_r_addr),
        .arr_r_data   (arr_r_data),
        .arr_w_en     (arr_w_en),
        .arr_w_addr   (arr_w_addr),
        .arr_w_data   (arr_w_data),
        .arr_w_maskOH (arr_w_maskOH)
    );

    always #5 clock = ~clock;

    // Two-port SRAM: registered read returning pre-write contents, per-way masked write.
    logic [LINE_W-1:0] sram [SETS];
    logic              scramble;
    always @(posedge clock) begin
        arr_r_data <= sram[arr_r_addr];
        if (scramble) begin
            for (int k = 0; k < SETS; k++) sram[k] <= LINE_W'($urandom);
        end else if (arr_w_en) begin
            for (int i = 0; i < WAYS; i++)
                if (arr_w_maskOH[i]) sram[arr_w_addr][i*STATE_W +: STATE_W] <= arr_w_data[i*STATE_W +: STATE_W];
        end
    end

    logic [LINE_W-1:0] ref_mem [SETS];
    int                remaining;
    logic              exp_v;
    logic [LINE_W-1:0] exp_s;
    logic [LINE_W-1:0] seen_resp;
    logic              seen_valid;
    int                n_assert = 0;
    int                n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_ref();
        for (int k = 0; k < SETS; k++) ref_mem[k] = '0;
    endtask

    task automatic cycle(input logic rst_n, input logic rv, input logic [SET_W-1:0] rs,
                         input logic wv, input logic [SET_W-1:0] ws, input logic [WAYS-1:0] wm,
                         input logic [STATE_W-1:0] wst, input logic fl);
        logic              rdy;
        logic              wacc;
        logic [LINE_W-1:0] line;
        reset               = rst_n;
        bus.io_rd_valid     = rv;
        bus.io_rd_set       = rs;
        bus.io_wr_valid     = wv;
        bus.io_wr_set       = ws;
        bus.io_wr_wayOH     = wm;
        bus.io_wr_state     = wst;
        bus.io_flush        = fl;
        @(negedge clock);
        seen_valid = bus.io_resp_valid;
        seen_resp  = bus.io_resp_state;
        chk("resp_valid", 32'(bus.io_resp_valid), 32'(exp_v));
        if (exp_v) chk("resp_state", 32'(bus.io_resp_state), 32'(exp_s));
        rdy  = (remaining == 0);
        wacc = rdy && wv && (wm != '0);
        chk("init_done", 32'(bus.io_init_done), 32'(rdy));
        chk("ready", 32'({bus.io_rd_ready, bus.io_wr_ready}), 32'({rdy, rdy}));
        if (!rdy) begin
            chk("sweep_write", 32'({arr_w_en, arr_w_addr, arr_w_maskOH, arr_w_data}),
                32'({1'b1, SET_W'(SETS - remaining), 4'hF, 8'h00}));
        end else begin
            chk("w_en", 32'(arr_w_en), 32'(wacc));
            if (wacc) chk("w_cmd", 32'({arr_w_addr, arr_w_maskOH, arr_w_data}), 32'({ws, wm, {WAYS{wst}}}));
            if (rv) chk("r_addr", 32'(arr_r_addr), 32'(rs));
        end
        line = ref_mem[rs];
        if (wacc) begin
            for (int i = 0; i < WAYS; i++)
                if (wm[i]) ref_mem[ws][i*STATE_W +: STATE_W] = wst;
            if (ws == rs) line = ref_mem[rs];
        end
        exp_v = rdy && rv;
        exp_s = line;
        if (!rdy) remaining--;
        else if (fl) begin
            remaining = SETS;
            clear_ref();
        end
        if (!rst_n) begin
            remaining = SETS;
            exp_v     = 1'b0;
            clear_ref();
        end
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic rd(input logic [SET_W-1:0] s);
        cycle(1'b1, 1'b1, s, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic wr(input logic [SET_W-1:0] s, input logic [WAYS-1:0] m, input logic [STATE_W-1:0] v);
        cycle(1'b1, 1'b0, '0, 1'b1, s, m, v, 1'b0);
    endtask

    initial begin
        remaining = SETS;
        exp_v     = 1'b0;
        exp_s     = '0;
        clear_ref();
        reset = 1'b0;
        scramble = 1'b1;
        bus.io_flush = 1'b0; bus.io_rd_valid = 1'b0; bus.io_rd_set = '0;
        bus.io_wr_valid = 1'b0; bus.io_wr_set = '0; bus.io_wr_wayOH = '0; bus.io_wr_state = '0;
        repeat (2) @(posedge clock);
        #1;
        scramble = 1'b0;
        repeat (2) cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);

        // Initial sweep: 512 clear writes, then ready.
        repeat (SETS) idle();
        chk("init_done_after_sweep", 32'(bus.io_init_done), 32'd1);

        rd(9'd300); idle();
        chk("rd300", 32'({seen_valid, seen_resp}), 32'({1'b1, 8'h00}));

        wr(9'd5, 4'b0100, 2'd3); rd(9'd5); idle();
        chk("set5_a", 32'(seen_resp), 32'h30);
        wr(9'd5, 4'b0011, 2'd2); rd(9'd5); idle();
        chk("set5_b", 32'(seen_resp), 32'h3A);

        cycle(1'b1, 1'b1, 9'd7, 1'b1, 9'd7, 4'b0010, 2'd2, 1'b0); idle();
        chk("set7_fwd", 32'(seen_resp), 32'h08);
        cycle(1'b1, 1'b1, 9'd7, 1'b1, 9'd8, 4'b1111, 2'd3, 1'b0); idle();
        chk("set7_other", 32'(seen_resp), 32'h08);
        cycle(1'b1, 1'b1, 9'd8, 1'b1, 9'd8, 4'b0000, 2'd1, 1'b0); idle();
        chk("zero_mask_noop", 32'(seen_resp), 32'hFF);

        wr(9'd9, 4'b1111, 2'd3);
        cycle(1'b1, 1'b1, 9'd9, 1'b0, '0, '0, '0, 1'b1);
        idle();
        chk("flush_rd9", 32'({seen_valid, seen_resp}), 32'({1'b1, 8'hFF}));
        repeat (SETS - 1) idle();
        rd(9'd9); idle();
        chk("rd9_cleared", 32'(seen_resp), 32'h00);

        // Reset while the sweep is at set 100 restarts it from set 0.
        cycle(1'b1, 1'b1, 9'd3, 1'b0, '0, '0, '0, 1'b1);
        repeat (100) idle();
        chk("sweep_at_100", 32'(arr_w_addr), 32'd100);
        cycle(1'b0, 1'b0, '0, 1'b0, '0, '0, '0, 1'b0);
        chk("restart_addr0", 32'(arr_w_addr), 32'd0);
        repeat (SETS) idle();
        chk("init_done_after_restart", 32'(bus.io_init_done), 32'd1);

        for (int n = 0; n < 2000; n++) begin
            cycle(1'b1,
                  ($urandom_range(0, 3) != 0), SET_W'($urandom_range(0, 15)),
                  ($urandom_range(0, 1) != 0), SET_W'($urandom_range(0, 15)),
                  WAYS'($urandom), STATE_W'($urandom),
                  ($urandom_range(0, 399) == 0));
        end
        repeat (2) idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
